// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: EX-stage redirect inputs, hazard stall, imem handshake
// and the registered fetch-side outputs of the PC sequencer.
interface pc_sequencer_if;
    logic        bcmp;
    logic        jump;
    logic [31:0] target;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic        flush;
    logic [7:0]  redirect_cnt;

    modport master (
        input  bcmp, jump, target, stall, imem_ready,
        output pc, imem_req, flush, redirect_cnt
    );

    modport slave (
        output bcmp, jump, target, stall, imem_ready,
        input  pc, imem_req, flush, redirect_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address FSM (BOOT/FETCH/WAIT/FLUSH) with branch
// redirect, stall hold, imem handshake and saturating redirect counter.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {BOOT, FETCH, WAIT, FLUSH} state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic        flush_q, flush_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        armed_q;
    logic        redirect;

    assign redirect = bus.bcmp & bus.jump;

    // BOOT spans the first full clock cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed_q <= 1'b0;
        else        armed_q <= 1'b1;
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= PC_INIT;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state: redirect beats stall beats imem_ready
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: begin
                if (armed_q) state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (redirect) begin
                    pc_d    = {bus.target[31:2], 2'b00};
                    state_d = FLUSH;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (bus.stall) begin
                    state_d = state_q;
                end else if (bus.imem_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            FLUSH: begin
                state_d = FETCH;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // outputs follow the state being entered so they stay registered
    always_comb begin
        req_d   = (state_d == FETCH) || (state_d == WAIT);
        flush_d = (state_d == FLUSH);
    end

    assign bus.pc           = pc_q;
    assign bus.imem_req     = req_q;
    assign bus.flush        = flush_q;
    assign bus.redirect_cnt = cnt_q;

endmodule
